// File: rtl/adlib_reg_ctrl.sv
// ---------------------------------------------------------------------------
// adlib_reg_ctrl
//
// OPL2-compatible register front end for the AdLib synth.
//   - CPU writes land on the index port (bus_addr=0) or data port (bus_addr=1).
//   - A data-port write is decoded from the latched index and produces, one
//     clock later, a single-cycle write strobe for the operator/channel array
//     together with op_din / op_sel / ch_sel (these hold until the next
//     decoded operator/channel write).
//   - Holds the per-channel key-on bits (ch_play), the waveform-select
//     enable, and the two OPL2 timers (80 us and 320 us resolution) with the
//     sticky status flags, the registered status byte and the IRQ.
//
// Build option:
//   ADLIB_RHYTHM_EN  when defined, register 0xBD is decoded and the rhythm
//                    instrument bits are OR-ed into the key-on of channels
//                    6..8 while rhythm mode (bit 5) is set. When undefined,
//                    index 0xBD is unmapped and no rhythm state exists.
// ---------------------------------------------------------------------------
module adlib_reg_ctrl #(
  parameter int TICK_DIV = 4000  // clocks per 80 us timer tick, minimum 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_wr,
  input  logic       bus_addr,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       irq,
  output logic [7:0] op_din,
  output logic [4:0] op_sel,
  output logic [3:0] ch_sel,
  output logic       wr_2n,
  output logic       wr_4n,
  output logic       wr_6n,
  output logic       wr_8n,
  output logic       wr_En,
  output logic       wr_An,
  output logic       wr_Bn,
  output logic       wr_Cn,
  output logic [8:0] ch_play
);

  // -------------------------------------------------------------------------
  // Local types and constants
  // -------------------------------------------------------------------------
  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  // What the currently latched index addresses.
  typedef enum logic [3:0] {
    K_NONE,   // unmapped index
    K_OP20,   // operator AM/VIB/EG/KSR/MULT
    K_OP40,   // operator KSL/TL
    K_OP60,   // operator AR/DR
    K_OP80,   // operator SL/RR
    K_OPE0,   // operator waveform select
    K_CHA,    // channel F-number low
    K_CHB,    // channel key-on/block/F-number high
    K_CHC,    // channel feedback/connection
    K_WSE,    // reg 0x01, waveform-select enable
    K_T1P,    // reg 0x02, timer 1 preset
    K_T2P,    // reg 0x03, timer 2 preset
    K_TCTL,   // reg 0x04, timer control / flag reset
    K_RHY     // reg 0xBD, rhythm control (optional)
  } reg_kind_e;

  // -------------------------------------------------------------------------
  // Bus qualification and decode
  // -------------------------------------------------------------------------
  logic       idx_wr;
  logic       data_wr;
  logic [7:0] index_q;
  reg_kind_e  kind;

  logic [4:0] op_off;
  logic       op_ok;
  logic       ch_ok;
  logic [4:0] op_slot;
  logic       is_op;
  logic       is_ch;

  assign idx_wr  = bus_wr & ~bus_addr;
  assign data_wr = bus_wr &  bus_addr;

  // Classify the latched index and compute the operator slot it addresses.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave it unassigned and turn it into a latch.
    kind    = K_NONE;
    op_off  = index_q[4:0];
    // Offsets are laid out as three rows of eight with six live operators per
    // row; the last two of each row and everything from 0x16 up are holes.
    op_ok   = (op_off < 5'h16) && (op_off[2:0] < 3'd6);
    ch_ok   = (index_q[3:0] <= 4'd8);
    op_slot = (5'(op_off[4:3]) * 5'd6) + 5'(op_off[2:0]);

    case (index_q[7:4])
      4'h0: begin
        case (index_q[3:0])
          4'h1:    kind = K_WSE;
          4'h2:    kind = K_T1P;
          4'h3:    kind = K_T2P;
          4'h4:    kind = K_TCTL;
          default: kind = K_NONE;
        endcase
      end
      4'h2, 4'h3: if (op_ok) kind = K_OP20;
      4'h4, 4'h5: if (op_ok) kind = K_OP40;
      4'h6, 4'h7: if (op_ok) kind = K_OP60;
      4'h8, 4'h9: if (op_ok) kind = K_OP80;
      4'hE, 4'hF: if (op_ok) kind = K_OPE0;
      4'hA:       if (ch_ok) kind = K_CHA;
      4'hB: begin
        if (ch_ok) kind = K_CHB;
`ifdef ADLIB_RHYTHM_EN
        if (index_q[3:0] == 4'hD) kind = K_RHY;
`endif
      end
      4'hC:       if (ch_ok) kind = K_CHC;
      default:    kind = K_NONE;
    endcase
  end

  assign is_op = (kind == K_OP20) || (kind == K_OP40) || (kind == K_OP60) ||
                 (kind == K_OP80) || (kind == K_OPE0);
  assign is_ch = (kind == K_CHA)  || (kind == K_CHB)  || (kind == K_CHC);

  // -------------------------------------------------------------------------
  // Index latch and global configuration registers
  // -------------------------------------------------------------------------
  logic       wse_q;
  logic [7:0] t1_preset;
  logic [7:0] t2_preset;

  // Latch the index on index-port writes; capture 0x01..0x03 on data writes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values no matter how the blocks are ordered.
    if (!rst_n) begin
      index_q   <= 8'h00;
      wse_q     <= 1'b0;
      t1_preset <= 8'h00;
      t2_preset <= 8'h00;
    end else begin
      if (idx_wr) index_q <= bus_din;
      if (data_wr) begin
        case (kind)
          K_WSE:   wse_q     <= bus_din[5];
          K_T1P:   t1_preset <= bus_din;
          K_T2P:   t2_preset <= bus_din;
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operator/channel write strobes, datapath outputs and key-on bits
  // -------------------------------------------------------------------------
  logic [7:0] e0_data;
  logic [8:0] key_q;

  // Waveform select only passes the two low bits, and only once enabled.
  assign e0_data = wse_q ? {6'b000000, bus_din[1:0]} : 8'h00;

  // Registered decode: strobes are high for exactly the cycle after the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_2n  <= 1'b0;
      wr_4n  <= 1'b0;
      wr_6n  <= 1'b0;
      wr_8n  <= 1'b0;
      wr_En  <= 1'b0;
      wr_An  <= 1'b0;
      wr_Bn  <= 1'b0;
      wr_Cn  <= 1'b0;
      op_din <= 8'h00;
      op_sel <= 5'd0;
      ch_sel <= 4'd0;
      key_q  <= 9'h000;
    end else begin
      wr_2n <= data_wr && (kind == K_OP20);
      wr_4n <= data_wr && (kind == K_OP40);
      wr_6n <= data_wr && (kind == K_OP60);
      wr_8n <= data_wr && (kind == K_OP80);
      wr_En <= data_wr && (kind == K_OPE0);
      wr_An <= data_wr && (kind == K_CHA);
      wr_Bn <= data_wr && (kind == K_CHB);
      wr_Cn <= data_wr && (kind == K_CHC);

      if (data_wr && is_op) begin
        op_sel <= op_slot;
        op_din <= (kind == K_OPE0) ? e0_data : bus_din;
      end

      if (data_wr && is_ch) begin
        ch_sel <= index_q[3:0];
        op_din <= bus_din;
      end

      // Key-on changes on the same edge that raises wr_Bn.
      if (data_wr && (kind == K_CHB)) key_q[index_q[3:0]] <= bus_din[5];
    end
  end

  // -------------------------------------------------------------------------
  // Timer prescaler: free-running, untouched by register writes
  // -------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [1:0]    div4_q;
  logic          tick80;
  logic          tick320;

  assign tick80  = (presc_q == PRESC_MAX);
  assign tick320 = tick80 && (div4_q == 2'd3);

  // 80 us prescaler plus a divide-by-four for the 320 us timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      div4_q  <= 2'd0;
    end else if (tick80) begin
      presc_q <= '0;
      div4_q  <= div4_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Timers 1 and 2
  // -------------------------------------------------------------------------
  logic       ctl_wr;
  logic       flag_clr;
  logic       ctl_set;
  logic       start1, start2;
  logic       mask1, mask2;
  logic [7:0] cnt1, cnt2;
  logic       ovf1, ovf2;
  logic       t1_flag, t2_flag;

  // Bit 7 of reg 0x04 turns the whole write into a pure flag reset.
  assign ctl_wr   = data_wr && (kind == K_TCTL);
  assign flag_clr = ctl_wr &&  bus_din[7];
  assign ctl_set  = ctl_wr && ~bus_din[7];

  // Overflow only counts while running; a masked timer keeps counting silently.
  assign ovf1 = start1 && tick80  && (cnt1 == 8'hFF) && !mask1;
  assign ovf2 = start2 && tick320 && (cnt2 == 8'hFF) && !mask2;

  // Timer 1: 80 us ticks, reload from preset on start and on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start1 <= 1'b0;
      mask1  <= 1'b0;
      cnt1   <= 8'h00;
    end else begin
      if (ctl_set) begin
        mask1  <= bus_din[6];
        start1 <= bus_din[0];
      end
      if (ctl_set && bus_din[0] && !start1)
        cnt1 <= t1_preset;
      else if (start1 && tick80)
        cnt1 <= (cnt1 == 8'hFF) ? t1_preset : cnt1 + 8'd1;
    end
  end

  // Timer 2: 320 us ticks, same reload rules as timer 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start2 <= 1'b0;
      mask2  <= 1'b0;
      cnt2   <= 8'h00;
    end else begin
      if (ctl_set) begin
        mask2  <= bus_din[5];
        start2 <= bus_din[1];
      end
      if (ctl_set && bus_din[1] && !start2)
        cnt2 <= t2_preset;
      else if (start2 && tick320)
        cnt2 <= (cnt2 == 8'hFF) ? t2_preset : cnt2 + 8'd1;
    end
  end

  // Sticky overflow flags; a reset write beats a same-cycle overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_flag <= 1'b0;
      t2_flag <= 1'b0;
    end else if (flag_clr) begin
      t1_flag <= 1'b0;
      t2_flag <= 1'b0;
    end else begin
      if (ovf1) t1_flag <= 1'b1;
      if (ovf2) t2_flag <= 1'b1;
    end
  end

  // Status byte, registered one cycle behind the flags; IRQ is its top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_dout <= 8'h00;
    else        bus_dout <= {t1_flag | t2_flag, t1_flag, t2_flag, 5'b00000};
  end

  assign irq = bus_dout[7];

  // -------------------------------------------------------------------------
  // Effective key-on, optionally merged with the rhythm instruments
  // -------------------------------------------------------------------------
`ifdef ADLIB_RHYTHM_EN
  logic [5:0] rhy_q;  // [5] rhythm mode, [4] BD, [3] SD, [2] TT, [1] CY, [0] HH
  logic [8:0] rhy_play;

  // Capture rhythm mode and instrument bits from reg 0xBD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        rhy_q <= 6'b000000;
    else if (data_wr && kind == K_RHY) rhy_q <= bus_din[5:0];
  end

  // BD drives channel 6, SD/HH channel 7, TT/CY channel 8.
  assign rhy_play = rhy_q[5] ? {rhy_q[2] | rhy_q[1], rhy_q[3] | rhy_q[0], rhy_q[4], 6'b000000}
                             : 9'h000;
  assign ch_play  = key_q | rhy_play;
`else
  assign ch_play  = key_q;
`endif

endmodule

// File: tb/tb_adlib_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adlib_reg_ctrl
//
// Directed bench for adlib_reg_ctrl with TICK_DIV=4. Each decoded data write
// pushes its expected strobe/datapath/key-on picture onto a scoreboard queue;
// the entry is popped and compared on the cycle the DUT presents its strobe.
// Timer, status and reset behaviour are checked with directed comparisons.
// Define ADLIB_RHYTHM_EN for both files to exercise the rhythm register.
// ---------------------------------------------------------------------------
module tb_adlib_reg_ctrl;

  localparam int TICK_DIV = 4;

  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_2N   = 8'h80;
  localparam logic [7:0] S_4N   = 8'h40;
  localparam logic [7:0] S_6N   = 8'h20;
  localparam logic [7:0] S_8N   = 8'h10;
  localparam logic [7:0] S_EN   = 8'h08;
  localparam logic [7:0] S_AN   = 8'h04;
  localparam logic [7:0] S_BN   = 8'h02;
  localparam logic [7:0] S_CN   = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_wr = 1'b0;
  logic       bus_addr = 1'b0;
  logic [7:0] bus_din = 8'h00;
  logic [7:0] bus_dout;
  logic       irq;
  logic [7:0] op_din;
  logic [4:0] op_sel;
  logic [3:0] ch_sel;
  logic       wr_2n, wr_4n, wr_6n, wr_8n, wr_En, wr_An, wr_Bn, wr_Cn;
  logic [8:0] ch_play;
  logic [7:0] strb_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] strb;
    logic [7:0] din;
    logic [4:0] sel;
    logic [3:0] ch;
    logic [8:0] play;
  } exp_t;

  exp_t sb[$];

  // Values the DUT must be holding after the last decoded write.
  logic [7:0] h_din  = 8'h00;
  logic [4:0] h_sel  = 5'd0;
  logic [3:0] h_ch   = 4'd0;
  logic [8:0] h_play = 9'h000;

  adlib_reg_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_wr   (bus_wr),
    .bus_addr (bus_addr),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .irq      (irq),
    .op_din   (op_din),
    .op_sel   (op_sel),
    .ch_sel   (ch_sel),
    .wr_2n    (wr_2n),
    .wr_4n    (wr_4n),
    .wr_6n    (wr_6n),
    .wr_8n    (wr_8n),
    .wr_En    (wr_En),
    .wr_An    (wr_An),
    .wr_Bn    (wr_Bn),
    .wr_Cn    (wr_Cn),
    .ch_play  (ch_play)
  );

  assign strb_obs = {wr_2n, wr_4n, wr_6n, wr_8n, wr_En, wr_An, wr_Bn, wr_Cn};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; returns 1 ns after the sampling edge.
  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus_wr   = 1'b1;
    bus_addr = a;
    bus_din  = d;
    @(posedge clk);
    #1;
    bus_wr   = 1'b0;
    bus_addr = 1'b0;
    bus_din  = 8'h00;
  endtask

  task automatic reg_write(input logic [7:0] idx, input logic [7:0] d);
    bus_write(1'b0, idx);
    bus_write(1'b1, d);
  endtask

  // Pop the oldest expectation and compare against what the DUT shows now.
  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, " strobes"}, 32'(strb_obs), 32'(e.strb));
      check({e.tag, " op_din"},  32'(op_din),   32'(e.din));
      check({e.tag, " op_sel"},  32'(op_sel),   32'(e.sel));
      check({e.tag, " ch_sel"},  32'(ch_sel),   32'(e.ch));
      check({e.tag, " ch_play"}, 32'(ch_play),  32'(e.play));
    end
  endtask

  // Decoded write with its expected outcome, then the pulse-width check.
  task automatic step(input string tag, input logic [7:0] idx, input logic [7:0] d,
                      input logic [7:0] strb, input logic [7:0] din, input logic [4:0] sel,
                      input logic [3:0] ch, input logic [8:0] play);
    exp_t e;
    e.tag  = tag;
    e.strb = strb;
    e.din  = din;
    e.sel  = sel;
    e.ch   = ch;
    e.play = play;
    sb.push_back(e);
    reg_write(idx, d);
    sb_compare();
    h_din  = din;
    h_sel  = sel;
    h_ch   = ch;
    h_play = play;
    @(posedge clk);
    #1;
    check({tag, " pulse width"}, 32'(strb_obs), 32'(S_NONE));
    check({tag, " op_din hold"}, 32'(op_din),   32'(din));
  endtask

  // Write that must not strobe nor disturb the held datapath outputs.
  task automatic quiet(input string tag, input logic [7:0] idx, input logic [7:0] d);
    step(tag, idx, d, S_NONE, h_din, h_sel, h_ch, h_play);
  endtask

  initial begin
    int lat;
    int hits;

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check("reset strobes",  32'(strb_obs), 32'(S_NONE));
    check("reset op_din",   32'(op_din),   32'h00);
    check("reset op_sel",   32'(op_sel),   32'd0);
    check("reset ch_sel",   32'(ch_sel),   32'd0);
    check("reset ch_play",  32'(ch_play),  32'h000);
    check("reset bus_dout", 32'(bus_dout), 32'h00);
    check("reset irq",      32'(irq),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Operator decode, gaps and out-of-range offsets.
    step ("op 0x35",      8'h35, 8'h5A, S_2N, 8'h5A, 5'd17, 4'd0, 9'h000);
    quiet("gap 0x26",     8'h26, 8'h11);
    step ("op 0x4D",      8'h4D, 8'hC3, S_4N, 8'hC3, 5'd11, 4'd0, 9'h000);
    step ("op 0x60",      8'h60, 8'h01, S_6N, 8'h01, 5'd0,  4'd0, 9'h000);
    quiet("gap 0x8F",     8'h8F, 8'h55);
    quiet("off 0x76",     8'h76, 8'h55);
    step ("op 0x92",      8'h92, 8'h3C, S_8N, 8'h3C, 5'd14, 4'd0, 9'h000);

    // Waveform select gated by WSE.
    step ("E0 wse0",      8'hE0, 8'h03, S_EN, 8'h00, 5'd0,  4'd0, 9'h000);
    quiet("wse on",       8'h01, 8'h20);
    step ("E0 wse1",      8'hE0, 8'h03, S_EN, 8'h03, 5'd0,  4'd0, 9'h000);
    step ("E5 wse1",      8'hE5, 8'hFE, S_EN, 8'h02, 5'd5,  4'd0, 9'h000);

    // Channel decode and key-on.
    step ("A8",           8'hA8, 8'h77, S_AN, 8'h77, 5'd5,  4'd8, 9'h000);
    step ("B4 key on",    8'hB4, 8'h20, S_BN, 8'h20, 5'd5,  4'd4, 9'h010);
    step ("B4 key off",   8'hB4, 8'h00, S_BN, 8'h00, 5'd5,  4'd4, 9'h000);
    quiet("B9 unmapped",  8'hB9, 8'h20);
    step ("C3",           8'hC3, 8'h01, S_CN, 8'h01, 5'd5,  4'd3, 9'h000);
`ifndef ADLIB_RHYTHM_EN
    quiet("BD unmapped",  8'hBD, 8'h30);
`endif

    // Timer 1: preset 0xFE overflows on the second 80 us tick.
    reg_write(8'h02, 8'hFE);
    reg_write(8'h04, 8'h01);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        lat = k;
        break;
      end
    end
    check("t1 irq latency in 6..9", 32'(lat >= 6 && lat <= 9), 32'd1);
    check("t1 bus_dout",            32'(bus_dout), 32'hC0);
    check("t1 irq",                 32'(irq),      32'd1);
    reg_write(8'h04, 8'h80);
    check("clear dout lag",         32'(bus_dout), 32'hC0);
    @(posedge clk);
    #1;
    check("clear bus_dout",         32'(bus_dout), 32'h00);
    check("clear irq",              32'(irq),      32'd0);
    reg_write(8'h04, 8'h00);
    reg_write(8'h04, 8'h80);
    repeat (24) @(posedge clk);
    #1;
    check("t1 stopped",             32'(bus_dout), 32'h00);

    // Timer 2 masked and running: no flag, then unmask and it fires.
    reg_write(8'h03, 8'hFF);
    reg_write(8'h04, 8'h22);
    hits = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      if (irq) hits++;
    end
    check("t2 masked no irq",       32'(hits), 32'd0);
    reg_write(8'h04, 8'h02);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        lat = k;
        break;
      end
    end
    check("t2 unmasked fires",      32'(lat != 0), 32'd1);
    check("t2 bus_dout",            32'(bus_dout), 32'hA0);

`ifdef ADLIB_RHYTHM_EN
    // Rhythm mode adds BD to channel 6; leaving rhythm mode removes it.
    step("BD rhythm on",  8'hBD, 8'h30, S_NONE, h_din, h_sel, h_ch, 9'h040);
    step("BD rhythm off", 8'hBD, 8'h10, S_NONE, h_din, h_sel, h_ch, 9'h000);
`endif

    // Mid-operation reset while a strobe is high and key-on/irq are set.
    step("B2 key on", 8'hB2, 8'h20, S_BN, 8'h20, 5'd5, 4'd2, 9'h004);
    reg_write(8'h35, 8'h5A);
    check("pre-reset strobe",  32'(strb_obs), 32'(S_2N));
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst strobes",  32'(strb_obs), 32'(S_NONE));
    check("async rst op_din",   32'(op_din),   32'h00);
    check("async rst op_sel",   32'(op_sel),   32'd0);
    check("async rst ch_sel",   32'(ch_sel),   32'd0);
    check("async rst ch_play",  32'(ch_play),  32'h000);
    check("async rst bus_dout", 32'(bus_dout), 32'h00);
    check("async rst irq",      32'(irq),      32'd0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adlib_reg_ctrl.md
Name: adlib_reg_ctrl

Overview:
OPL2-compatible register front end for the AdLib synth. It takes CPU writes to the index port (0x388) and data port (0x389), decodes each indexed register into per-operator and per-channel write strobes, and drives the shared operator datapath. It also holds the per-channel key-on bits that drive operator `play`, runs Timer 1 (80 µs) and Timer 2 (320 µs), and returns the status byte and IRQ. It sits between the ISA bus glue and the operator/channel array.

Parameters:
TICK_DIV, 4000, clocks per 80 µs timer tick (4000 at 50 MHz); minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_wr  in  1  one-cycle CPU write strobe
bus_addr  in  1  0 = index port, 1 = data port
bus_din  in  8  CPU write data
bus_dout  out  8  status byte {irq, t1_flag, t2_flag, 5'b00000}
irq  out  1  timer interrupt, equals bus_dout[7]
op_din  out  8  data for operator/channel register writes
op_sel  out  5  operator slot 0..17
ch_sel  out  4  channel 0..8
wr_2n  out  1  one-cycle strobe, operator reg 0x20 group
wr_4n  out  1  one-cycle strobe, operator reg 0x40 group
wr_6n  out  1  one-cycle strobe, operator reg 0x60 group
wr_8n  out  1  one-cycle strobe, operator reg 0x80 group
wr_En  out  1  one-cycle strobe, operator reg 0xE0 group
wr_An  out  1  one-cycle strobe, channel F-number low
wr_Bn  out  1  one-cycle strobe, channel key/block/F-number high
wr_Cn  out  1  one-cycle strobe, channel feedback/connection
ch_play  out  9  key-on per channel

Behaviour:
- Reset: index=0, WSE=0, all strobes 0, op_din/op_sel/ch_sel=0, ch_play=0, timers stopped with count 0, presets 0, flags 0, masks 0, prescaler 0.
- Index-port write (bus_wr & ~bus_addr): index <= bus_din. No strobes.
- Data-port write on cycle N: decode is registered. On N+1, exactly one strobe is high for one cycle, with op_din/op_sel/ch_sel valid; these three hold until the next decoded write. Unmapped index: no strobe, no state change.
- Operator decode for groups 0x20/0x40/0x60/0x80/0xE0: offset o = index[4:0].
  - Valid only if o < 0x16 and o[2:0] < 6.
  - op_sel = o[4:3]*6 + o[2:0].
  - Gap offsets (0x06, 0x07, 0x0E, 0x0F) and offsets 0x16..0x1F produce no strobe.
  - 0xE0 group: op_din = WSE ? {6'b0, din[1:0]} : 8'h00.
- Channel decode: index[7:4] ∈ {A, B, C} and index[3:0] ≤ 8 → wr_An/wr_Bn/wr_Cn, ch_sel = index[3:0]. Index[3:0] > 8 produces no strobe.
- Bn write: ch_play[ch] <= din[5] on the same edge the strobe asserts.
- Reg 0x01: WSE <= din[5].
- Reg 0x02: T1 preset. Reg 0x03: T2 preset.
- Reg 0x04:
  - If din[7]=1: clear t1_flag and t2_flag only. All other bits are ignored.
  - Else: mask1 <= din[6], mask2 <= din[5], start2 <= din[1], start1 <= din[0].
  - A 0→1 start transition loads count from the preset.
  - Start = 0 freezes the count.
- Prescaler: counts 0..TICK_DIV−1 and emits tick80 on wrap. A second divider emits tick320 on every 4th tick80. The prescaler free-runs and is never reset by register writes.
- Timer behaviour: on its tick, a running timer with count = 0xFF reloads the preset and sets its flag unless masked; otherwise it increments. Preset 0xFF therefore overflows every tick.
- Simultaneous overflow and flag-clear write in the same cycle: the clear wins.
- Flags are sticky. irq = t1_flag | t2_flag. bus_dout is registered, one cycle latency from flag change.
- Mid-operation reset: everything returns to reset values immediately. Strobes drop asynchronously.

Optional Feature:
ADLIB_RHYTHM_EN.
- Defined: reg 0xBD is decoded. Bit5 = rhythm mode. When rhythm=1, the effective ch_play[6] |= din[4] (BD), ch_play[7] |= din[3] | din[0] (SD, HH), ch_play[8] |= din[2] | din[1] (TT, CY). Rhythm bits reset to 0. Clearing bit5 removes their contribution.
- Undefined: index 0xBD is unmapped and no rhythm state is implemented.

Test Plan:
- Write index 0x35, data 0x5A → wr_2n pulses exactly one cycle at N+1; op_sel=17, op_din=0x5A. Index 0x26 then data → no strobe.
- WSE=0, write 0xE0=0x03 → wr_En with op_din=0x00. Set 0x01=0x20, rewrite → op_din=0x03.
- Write 0xB4=0x20 → ch_play=9'h010, wr_Bn with ch_sel=4. Then 0xB4=0x00 → ch_play=0. Write 0xB9 → no strobe.
- TICK_DIV=4, 0x02=0xFE, 0x04=0x01 → t1_flag sets after the 2nd tick80 (8 clocks + 1 for dout); irq=1, bus_dout=0xC0. Write 0x04=0x80 → bus_dout=0x00.
- 0x03=0xFF, 0x04=0x22 (T2 masked, started) → count wraps every 16 clocks, flag never sets. Assert rst_n low mid-count → all outputs 0.
- (ADLIB_RHYTHM_EN) write 0xBD=0x30 → ch_play[6]=1. Write 0xBD=0x10 → ch_play[6]=0.
